// File: rtl/mul_16_seq.sv
// Sequential 16x16 shift-and-add multiplier returning the low 16 bits of the
// product. A single add_16 instance performs every accumulate step.

// Combinational 16-bit ripple-carry adder; carry-out is discarded (wrap-around).
module add_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    localparam int unsigned W = 16;

    logic carry;

    // Ripple the carry from bit 0 upward; final carry is dropped.
    always_comb begin
        sum   = '0;
        carry = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end

endmodule

// Controller that sequences one add_16 through a fixed 16-step loop.
module mul_16_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] out
);

    localparam int unsigned W     = 16;
    localparam int unsigned CW    = 5;
    localparam int unsigned ITERS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    mcand;
    logic [W-1:0]    mplier;
    logic [W-1:0]    acc;
    logic [CW-1:0]   count;
    logic [W-1:0]    sum;
    logic [W-1:0]    acc_next;

    // The only adder on the accumulate path.
    add_16 u_add (
        .a   (acc),
        .b   (mcand),
        .sum (sum)
    );

    // Accumulate only when the current multiplier bit is set.
    assign acc_next = mplier[0] ? sum : acc;

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            out    <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    // Fixed length: no early exit when mplier runs out of ones.
                    if (count == CW'(ITERS - 1)) begin
                        out   <= acc_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
